hv_assoc_search: RTL and testbench

- Consumer end of the query-HV interface driven by the encoder (qhv_o / qhv_valid_o / qhv_ready_i).
- Accepts one query hypervector and streams through the class-HV memory, one row per cycle.
- Computes the Hamming distance of each row to the query (XOR + popcount) and tracks the minimum.
- Returns the winning class index and its distance over a valid/ready handshake to the host CSR side.

---
 rtl/hv_assoc_search_if.sv | 34 +++
 rtl/hv_assoc_search.sv | 145 ++++++++++++++
 tb/tb_hv_assoc_search.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hv_assoc_search_if.sv
// Query/result/class-memory bus for hv_assoc_search.
// slave: the search block. master: encoder, class memory and host CSR side.
interface hv_assoc_search_if #(
   parameter int unsigned HVDimension = 512,
   parameter int unsigned NumClasses  = 32
);
   localparam int unsigned ClassAddrWidth = $clog2(NumClasses);
   localparam int unsigned DistWidth      = $clog2(HVDimension) + 1;

   logic [HVDimension-1:0]    qhv_i;
   logic                      qhv_valid_i;
   logic                      qhv_ready_o;
   logic [ClassAddrWidth:0]   num_classes_i;
   logic                      class_rd_en_o;
   logic [ClassAddrWidth-1:0] class_addr_o;
   logic [HVDimension-1:0]    class_data_i;
   logic [ClassAddrWidth-1:0] predict_o;
   logic [DistWidth-1:0]      hamm_dist_o;
   logic                      predict_valid_o;
   logic                      predict_ready_i;
   logic                      busy_o;

   modport slave (
      input  qhv_i, qhv_valid_i, num_classes_i, class_data_i, predict_ready_i,
      output qhv_ready_o, class_rd_en_o, class_addr_o, predict_o, hamm_dist_o,
             predict_valid_o, busy_o
   );

   modport master (
      output qhv_i, qhv_valid_i, num_classes_i, class_data_i, predict_ready_i,
      input  qhv_ready_o, class_rd_en_o, class_addr_o, predict_o, hamm_dist_o,
             predict_valid_o, busy_o
   );
endinterface

// File: rtl/hv_assoc_search.sv
// Associative search: streams class-HV rows past a latched query and reports
// the row with minimum Hamming distance (lowest index wins ties).
// Optional macro HV_ASSOC_SEARCH_EARLY_EXIT_EN: stop at the first exact match.
module hv_assoc_search #(
   parameter int unsigned HVDimension    = 512,
   parameter int unsigned NumClasses     = 32,
   parameter int unsigned ClassAddrWidth = $clog2(NumClasses),
   parameter int unsigned DistWidth      = $clog2(HVDimension) + 1
) (
   input logic              clk_i,
   input logic              rst_ni,
   hv_assoc_search_if.slave bus
);
   localparam int unsigned CntWidth = ClassAddrWidth + 1;

   typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} state_e;

   state_e                    state_q;
   logic [HVDimension-1:0]    qhv_q;
   logic [CntWidth-1:0]       n_q;
   logic [DistWidth-1:0]      min_dist_q;
   logic [ClassAddrWidth-1:0] min_idx_q;
   logic                      rd_vld_q;
   logic [ClassAddrWidth-1:0] rd_tag_q;

   logic [DistWidth-1:0]      dist_c;
   logic                      better_c;
   logic [DistWidth-1:0]      nxt_min_dist_c;
   logic [ClassAddrWidth-1:0] nxt_min_idx_c;
   logic                      last_addr_c;
   logic [CntWidth-1:0]       n_sel_c;
`ifdef HV_ASSOC_SEARCH_EARLY_EXIT_EN
   logic                      hit_c;
`endif

   function automatic logic [DistWidth-1:0] popcount(input logic [HVDimension-1:0] v);
      logic [DistWidth-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < HVDimension; i++) begin
         c = c + DistWidth'(v[i]);
      end
      return c;
   endfunction

   // Distance of the returning row and running-minimum candidate
   always_comb begin
      dist_c         = popcount(qhv_q ^ bus.class_data_i);
      better_c       = rd_vld_q && (dist_c < min_dist_q);
      nxt_min_dist_c = better_c ? dist_c   : min_dist_q;
      nxt_min_idx_c  = better_c ? rd_tag_q : min_idx_q;
      last_addr_c    = ({1'b0, bus.class_addr_o} == (n_q - CntWidth'(1)));
      n_sel_c        = (bus.num_classes_i > CntWidth'(NumClasses)) ?
                       CntWidth'(NumClasses) : bus.num_classes_i;
`ifdef HV_ASSOC_SEARCH_EARLY_EXIT_EN
      hit_c          = rd_vld_q && (dist_c == '0);
`endif
   end

   // Search FSM, read pipeline and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q             <= IDLE;
         qhv_q               <= '0;
         n_q                 <= '0;
         min_dist_q          <= '0;
         min_idx_q           <= '0;
         rd_vld_q            <= 1'b0;
         rd_tag_q            <= '0;
         bus.qhv_ready_o     <= 1'b1;
         bus.class_rd_en_o   <= 1'b0;
         bus.class_addr_o    <= '0;
         bus.predict_o       <= '0;
         bus.hamm_dist_o     <= '0;
         bus.predict_valid_o <= 1'b0;
         bus.busy_o          <= 1'b0;
      end else begin
         rd_vld_q <= bus.class_rd_en_o;
         rd_tag_q <= bus.class_addr_o;
         if (better_c) begin
            min_dist_q <= dist_c;
            min_idx_q  <= rd_tag_q;
         end

         unique case (state_q)
            IDLE: begin
               if (bus.qhv_valid_i && bus.qhv_ready_o) begin
                  qhv_q           <= bus.qhv_i;
                  n_q             <= n_sel_c;
                  min_dist_q      <= DistWidth'(HVDimension);
                  min_idx_q       <= '0;
                  bus.qhv_ready_o <= 1'b0;
                  bus.busy_o      <= 1'b1;
                  if (n_sel_c == '0) begin
                     state_q             <= DONE;
                     bus.predict_o       <= '0;
                     bus.hamm_dist_o     <= DistWidth'(HVDimension);
                     bus.predict_valid_o <= 1'b1;
                  end else begin
                     state_q           <= SEARCH;
                     bus.class_rd_en_o <= 1'b1;
                     bus.class_addr_o  <= '0;
                  end
               end
            end

            SEARCH: begin
               if (last_addr_c) begin
                  state_q           <= DRAIN;
                  bus.class_rd_en_o <= 1'b0;
               end else begin
                  bus.class_addr_o <= bus.class_addr_o + ClassAddrWidth'(1);
               end
`ifdef HV_ASSOC_SEARCH_EARLY_EXIT_EN
               if (hit_c) begin
                  state_q             <= DONE;
                  bus.class_rd_en_o   <= 1'b0;
                  rd_vld_q            <= 1'b0;
                  bus.predict_o       <= rd_tag_q;
                  bus.hamm_dist_o     <= '0;
                  bus.predict_valid_o <= 1'b1;
               end
`endif
            end

            DRAIN: begin
               state_q             <= DONE;
               bus.predict_o       <= nxt_min_idx_c;
               bus.hamm_dist_o     <= nxt_min_dist_c;
               bus.predict_valid_o <= 1'b1;
            end

            DONE: begin
               if (bus.predict_ready_i) begin
                  state_q             <= IDLE;
                  bus.predict_valid_o <= 1'b0;
                  bus.qhv_ready_o     <= 1'b1;
                  bus.busy_o          <= 1'b0;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hv_assoc_search.sv
// Directed self-checking bench for hv_assoc_search (512-bit HVs, 32 classes).
module tb_hv_assoc_search;
   localparam int unsigned HV = 512;
   localparam int unsigned NC = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   hv_assoc_search_if #(.HVDimension(HV), .NumClasses(NC)) bus();

   hv_assoc_search dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Class memory with one-cycle read latency plus a log of issued addresses
   logic [HV-1:0] mem [NC];
   logic [AW-1:0] addr_hist [1024];
   int unsigned   rd_total = 0;

   always @(posedge clk) begin
      if (bus.class_rd_en_o) begin
         bus.class_data_i              <= mem[bus.class_addr_o];
         addr_hist[rd_total[9:0]]      <= bus.class_addr_o;
         rd_total                      <= rd_total + 1;
      end
   end

   function automatic logic [HV-1:0] ones_low(input int n);
      logic [HV-1:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[i] = 1'b1;
      return r;
   endfunction

   // Called #1 after an edge; returns after the accept edge (+#1)
   task automatic do_accept(input logic [HV-1:0] q, input logic [5:0] n,
                            input bit keep_valid, output bit ok,
                            output int unsigned snap);
      int w;
      bus.qhv_i         = q;
      bus.num_classes_i = n;
      bus.qhv_valid_i   = 1'b1;
      w = 0;
      while (bus.qhv_ready_o !== 1'b1 && w < 100) begin
         @(posedge clk); #1; w++;
      end
      ok   = (bus.qhv_ready_o === 1'b1);
      snap = rd_total;
      @(posedge clk); #1;
      if (!keep_valid) bus.qhv_valid_i = 1'b0;
   endtask

   // Latency in cycles counted from the accept cycle; -1 on timeout
   task automatic wait_result(output int lat);
      lat = 1;
      while (bus.predict_valid_o !== 1'b1 && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      if (bus.predict_valid_o !== 1'b1) lat = -1;
   endtask

   task automatic release_result();
      bus.predict_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.predict_ready_i = 1'b0;
   endtask

   task automatic load_basic_rows();
      mem[0] = '0;
      mem[1] = '1;
      mem[2] = {128{4'hA}};
      mem[3] = {128{4'h5}};
   endtask

   task automatic test_reset();
      bus.qhv_i = '0; bus.qhv_valid_i = 1'b0; bus.num_classes_i = '0;
      bus.predict_ready_i = 1'b0;
      #12;
      checks++;
      if ({bus.qhv_ready_o, bus.class_rd_en_o, bus.class_addr_o, bus.predict_o,
           bus.hamm_dist_o, bus.predict_valid_o, bus.busy_o} !==
          {1'b1, 1'b0, 5'd0, 5'd0, 10'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values got rdy=%b rd=%b addr=%0d pred=%0d dist=%0d pv=%b busy=%b",
                  bus.qhv_ready_o, bus.class_rd_en_o, bus.class_addr_o, bus.predict_o,
                  bus.hamm_dist_o, bus.predict_valid_o, bus.busy_o);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [HV-1:0] q;
      bit ok; int unsigned snap; int lat; bit seq_ok;
      load_basic_rows();
      q = '1; q[4:0] = 5'b0;
      do_accept(q, 6'd4, 1'b0, ok, snap);
      checks++;
      if (!ok || bus.busy_o !== 1'b1 || bus.qhv_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_accept ok=%b busy=%b rdy=%b want 1 1 0", ok, bus.busy_o, bus.qhv_ready_o);
      end
      wait_result(lat);
      checks++;
      if (lat !== 6) begin errors++; $display("FAIL basic_latency got %0d want 6", lat); end
      checks++;
      if (bus.predict_o !== 5'd1 || bus.hamm_dist_o !== 10'd5) begin
         errors++;
         $display("FAIL basic_result got %0d/%0d want 1/5", bus.predict_o, bus.hamm_dist_o);
      end
      seq_ok = (rd_total - snap == 4);
      for (int i = 0; i < 4; i++) if (addr_hist[10'(snap + i)] !== AW'(i)) seq_ok = 1'b0;
      checks++;
      if (!seq_ok) begin
         errors++;
         $display("FAIL basic_addr_seq reads=%0d want 4 with addresses 0..3", rd_total - snap);
      end
      release_result();
      checks++;
      if (bus.qhv_ready_o !== 1'b1 || bus.predict_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_release rdy=%b pv=%b busy=%b want 1 0 0",
                  bus.qhv_ready_o, bus.predict_valid_o, bus.busy_o);
      end
   endtask

   task automatic test_tie();
      bit ok; int unsigned snap; int lat;
      mem[0] = ones_low(7);
      mem[1] = ones_low(100);
      mem[2] = ones_low(7);
      mem[3] = ones_low(100) << 200;
      do_accept('0, 6'd4, 1'b0, ok, snap);
      wait_result(lat);
      checks++;
      if (bus.predict_o !== 5'd0 || bus.hamm_dist_o !== 10'd7 || lat !== 6) begin
         errors++;
         $display("FAIL tie_result got %0d/%0d lat=%0d want 0/7 lat=6", bus.predict_o, bus.hamm_dist_o, lat);
      end
      release_result();
   endtask

   task automatic test_zero_classes();
      bit ok; int unsigned snap; int lat;
      do_accept('1, 6'd0, 1'b0, ok, snap);
      wait_result(lat);
      checks++;
      if (lat !== 1 || bus.predict_o !== 5'd0 || bus.hamm_dist_o !== 10'd512) begin
         errors++;
         $display("FAIL zero_result got %0d/%0d lat=%0d want 0/512 lat=1", bus.predict_o, bus.hamm_dist_o, lat);
      end
      checks++;
      if (rd_total != snap) begin
         errors++;
         $display("FAIL zero_reads got %0d want 0", rd_total - snap);
      end
      release_result();
   endtask

   task automatic test_clamp();
      bit ok; int unsigned snap; int lat;
      for (int i = 0; i < 32; i++) mem[i] = ones_low(40 - i);
      do_accept('0, 6'd40, 1'b0, ok, snap);
      wait_result(lat);
      checks++;
      if (rd_total - snap != 32 || addr_hist[10'(snap + 31)] !== 5'd31) begin
         errors++;
         $display("FAIL clamp_reads got %0d want 32", rd_total - snap);
      end
      checks++;
      if (bus.predict_o !== 5'd31 || bus.hamm_dist_o !== 10'd9 || lat !== 34) begin
         errors++;
         $display("FAIL clamp_result got %0d/%0d lat=%0d want 31/9 lat=34", bus.predict_o, bus.hamm_dist_o, lat);
      end
      release_result();
   endtask

   task automatic test_back_to_back();
      logic [HV-1:0] q;
      bit ok; int unsigned snap; int lat; int bad;
      load_basic_rows();
      q = '1; q[4:0] = 5'b0;
      do_accept(q, 6'd4, 1'b1, ok, snap);
      bus.qhv_i = '0;
      wait_result(lat);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if ({bus.predict_valid_o, bus.predict_o, bus.hamm_dist_o, bus.qhv_ready_o, bus.busy_o} !==
             {1'b1, 5'd1, 10'd5, 1'b0, 1'b1}) bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad != 0 || lat !== 6) begin
         errors++;
         $display("FAIL backpressure_hold unstable cycles=%0d lat=%0d want 0 and 6", bad, lat);
      end
      bus.predict_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.predict_ready_i = 1'b0;
      checks++;
      if (bus.qhv_ready_o !== 1'b1 || bus.predict_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_release rdy=%b pv=%b want 1 0", bus.qhv_ready_o, bus.predict_valid_o);
      end
      @(posedge clk); #1;
      bus.qhv_valid_i = 1'b0;
      checks++;
      if (bus.qhv_ready_o !== 1'b0 || bus.busy_o !== 1'b1 ||
          bus.class_rd_en_o !== 1'b1 || bus.class_addr_o !== 5'd0) begin
         errors++;
         $display("FAIL b2b_second_accept rdy=%b busy=%b rd=%b addr=%0d want 0 1 1 0",
                  bus.qhv_ready_o, bus.busy_o, bus.class_rd_en_o, bus.class_addr_o);
      end
      wait_result(lat);
      checks++;
      if (bus.predict_o !== 5'd0 || bus.hamm_dist_o !== 10'd0 || lat < 0) begin
         errors++;
         $display("FAIL b2b_second_result got %0d/%0d lat=%0d want 0/0", bus.predict_o, bus.hamm_dist_o, lat);
      end
      release_result();
   endtask

   task automatic test_mid_reset();
      logic [HV-1:0] q;
      bit ok; int unsigned snap; int lat; int w;
      load_basic_rows();
      q = '1; q[4:0] = 5'b0;
      do_accept(q, 6'd4, 1'b0, ok, snap);
      w = 0;
      while (!(bus.class_rd_en_o === 1'b1 && bus.class_addr_o === 5'd2) && w < 20) begin
         @(posedge clk); #1; w++;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (w >= 20 ||
          {bus.qhv_ready_o, bus.class_rd_en_o, bus.class_addr_o, bus.predict_o,
           bus.hamm_dist_o, bus.predict_valid_o, bus.busy_o} !==
          {1'b1, 1'b0, 5'd0, 5'd0, 10'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset_values w=%0d rdy=%b rd=%b addr=%0d pv=%b busy=%b",
                  w, bus.qhv_ready_o, bus.class_rd_en_o, bus.class_addr_o,
                  bus.predict_valid_o, bus.busy_o);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      do_accept(q, 6'd4, 1'b0, ok, snap);
      wait_result(lat);
      checks++;
      if (bus.predict_o !== 5'd1 || bus.hamm_dist_o !== 10'd5 || lat !== 6) begin
         errors++;
         $display("FAIL post_reset_result got %0d/%0d lat=%0d want 1/5 lat=6", bus.predict_o, bus.hamm_dist_o, lat);
      end
      release_result();
   endtask

   task automatic test_exact_match();
      logic [HV-1:0] q, r;
      bit ok; int unsigned snap; int lat; int exp_lat; int unsigned exp_reads;
      q = {128{4'h3}};
      r = q; r[2:0] = ~r[2:0];
      mem[0] = r;
      mem[1] = q;
      for (int i = 2; i < 8; i++) mem[i] = q ^ (ones_low(50) << (i * 10));
`ifdef HV_ASSOC_SEARCH_EARLY_EXIT_EN
      exp_lat = 4; exp_reads = 3;
`else
      exp_lat = 10; exp_reads = 8;
`endif
      do_accept(q, 6'd8, 1'b0, ok, snap);
      wait_result(lat);
      checks++;
      if (bus.predict_o !== 5'd1 || bus.hamm_dist_o !== 10'd0 || lat !== exp_lat) begin
         errors++;
         $display("FAIL exact_result got %0d/%0d lat=%0d want 1/0 lat=%0d",
                  bus.predict_o, bus.hamm_dist_o, lat, exp_lat);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rd_total - snap != exp_reads) begin
         errors++;
         $display("FAIL exact_reads got %0d want %0d", rd_total - snap, exp_reads);
      end
      release_result();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_zero_classes();
      test_clamp();
      test_back_to_back();
      test_mid_reset();
      test_exact_match();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
